draw_rect_multi: RTL

- Pipelined VGA overlay stage that draws up to NRECT rectangles on the incoming pixel stream.
- Each rectangle has runtime position, size, colour, fill/outline mode and blink control.
- Configuration is written into shadow registers at any time and committed to the active set at the start of vertical blank, so frames never tear.
- Sits in the vga_if chain between the timing/background stage and later overlay stages.

---
 rtl/draw_rect_multi_if.sv | 22 ++
 rtl/draw_rect_multi.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/draw_rect_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_if
// Description : VGA pixel-stream bundle (timing fields plus RGB444 colour)
//               passed between the stages of the video overlay chain.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in     (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out    (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport slave  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport master (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface
`default_nettype wire

// File: rtl/draw_rect_multi.sv
`default_nettype none
// ============================================================================
// Module      : draw_rect_multi
// Description : Two-stage VGA overlay drawing up to NRECT prioritised
//               rectangles (fill/outline, blink) with vblank-committed config.
// Revision    : 1.0 - initial release
// ============================================================================
module draw_rect_multi #(
    parameter  int NRECT        = 4,
    parameter  int BORDER       = 2,
    parameter  int BLINK_FRAMES = 30,
    parameter  int CW           = 11,
    localparam int c_IW         = (NRECT > 1) ? $clog2(NRECT) : 1
) (
    input  wire             clk,
    input  wire             rst,
    vga_if.in               vga_in,
    vga_if.out              vga_out,
    input  wire             cfg_we,
    input  wire  [c_IW-1:0] cfg_idx,
    input  wire  [CW-1:0]   cfg_x,
    input  wire  [CW-1:0]   cfg_y,
    input  wire  [CW-1:0]   cfg_w,
    input  wire  [CW-1:0]   cfg_h,
    input  wire  [11:0]     cfg_color,
    input  wire             cfg_en,
    input  wire             cfg_outline,
    input  wire             cfg_blink,
    output logic [7:0]      frame_cnt
);

    // Bound arithmetic width: wide enough for both the 11-bit counters and
    // x+w at CW+1 bits, so the right/bottom edge never wraps to zero.
    localparam int c_BW  = ((CW > 11) ? CW : 11) + 1;
    localparam int c_BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [c_BW-1:0]  c_B    = c_BW'(BORDER);
    localparam logic [c_BW-1:0]  c_B2   = c_BW'(2 * BORDER);
    localparam logic [c_BCW-1:0] c_BLAST = c_BCW'(BLINK_FRAMES - 1);

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [CW-1:0] w;
        logic [CW-1:0] h;
        logic [11:0]   color;
        logic          en;
        logic          outline;
        logic          blink;
    } rect_t;

    rect_t r_shadow      [NRECT];
    rect_t r_active      [NRECT];
    rect_t w_shadow_next [NRECT];
    rect_t w_wr_data;

    logic             w_wr;
    logic             w_commit;
    logic             r_vblnk_d;
    logic [7:0]       r_frame_cnt;
    logic [c_BCW-1:0] r_blink_cnt;
    logic             r_blink_phase;

    logic [NRECT-1:0] w_hit;
    logic [NRECT-1:0] r_s1_hit;
    logic [11:0]      r_s1_color [NRECT];
    logic [10:0]      r_s1_vcount, r_s1_hcount;
    logic             r_s1_vsync, r_s1_vblnk, r_s1_hsync, r_s1_hblnk;
    logic [11:0]      r_s1_rgb;
    logic [11:0]      w_sel_rgb;

    logic [10:0]      r_out_vcount, r_out_hcount;
    logic             r_out_vsync, r_out_vblnk, r_out_hsync, r_out_hblnk;
    logic [11:0]      r_out_rgb;

    assign w_wr      = cfg_we && (32'(cfg_idx) < 32'(NRECT));
    assign w_commit  = vga_in.vblnk && !r_vblnk_d;
    assign w_wr_data = '{x: cfg_x, y: cfg_y, w: cfg_w, h: cfg_h, color: cfg_color,
                         en: cfg_en, outline: cfg_outline, blink: cfg_blink};

    // A write landing on the commit cycle is folded into the committed set.
    always_comb begin
        w_shadow_next = r_shadow;
        if (w_wr) begin
            w_shadow_next[cfg_idx] = w_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NRECT; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
            r_vblnk_d     <= 1'b0;
            r_frame_cnt   <= 8'd0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_shadow  <= w_shadow_next;
            r_vblnk_d <= vga_in.vblnk;
            if (w_commit) begin
                r_active    <= w_shadow_next;
                r_frame_cnt <= r_frame_cnt + 8'd1;
                if (r_blink_cnt == c_BLAST) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= !r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + c_BCW'(1);
                end
            end
        end
    end

    assign frame_cnt = r_frame_cnt;

    generate
        for (genvar i = 0; i < NRECT; i++) begin : g_hit
            logic [c_BW-1:0] w_hc, w_vc;
            logic [c_BW-1:0] w_x0, w_y0, w_wd, w_ht, w_x1, w_y1;
            logic            w_in_x, w_in_y, w_inner_x, w_inner_y, w_thin;
            logic            w_shape, w_visible;

            assign w_hc = c_BW'(vga_in.hcount);
            assign w_vc = c_BW'(vga_in.vcount);
            assign w_x0 = c_BW'(r_active[i].x);
            assign w_y0 = c_BW'(r_active[i].y);
            assign w_wd = c_BW'(r_active[i].w);
            assign w_ht = c_BW'(r_active[i].h);
            assign w_x1 = w_x0 + w_wd;
            assign w_y1 = w_y0 + w_ht;

            // Empty ranges when w or h is zero fall out of the half-open test.
            assign w_in_x    = (w_hc >= w_x0) && (w_hc < w_x1);
            assign w_in_y    = (w_vc >= w_y0) && (w_vc < w_y1);
            assign w_inner_x = (w_hc >= w_x0 + c_B) && (w_hc < w_x1 - c_B);
            assign w_inner_y = (w_vc >= w_y0 + c_B) && (w_vc < w_y1 - c_B);
            assign w_thin    = (w_wd <= c_B2) || (w_ht <= c_B2);

            assign w_shape   = w_in_x && w_in_y &&
                               (!r_active[i].outline || w_thin || !(w_inner_x && w_inner_y));
            assign w_visible = !r_active[i].blink || !r_blink_phase;
            assign w_hit[i]  = r_active[i].en && w_shape && w_visible;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_hit <= '0;
            for (int i = 0; i < NRECT; i++) begin
                r_s1_color[i] <= 12'd0;
            end
            r_s1_vcount <= 11'd0;
            r_s1_vsync  <= 1'b0;
            r_s1_vblnk  <= 1'b0;
            r_s1_hcount <= 11'd0;
            r_s1_hsync  <= 1'b0;
            r_s1_hblnk  <= 1'b0;
            r_s1_rgb    <= 12'd0;
        end else begin
            r_s1_hit <= w_hit;
            for (int i = 0; i < NRECT; i++) begin
                r_s1_color[i] <= r_active[i].color;
            end
            r_s1_vcount <= vga_in.vcount;
            r_s1_vsync  <= vga_in.vsync;
            r_s1_vblnk  <= vga_in.vblnk;
            r_s1_hcount <= vga_in.hcount;
            r_s1_hsync  <= vga_in.hsync;
            r_s1_hblnk  <= vga_in.hblnk;
            r_s1_rgb    <= vga_in.rgb;
        end
    end

    // Scan from the highest index down so the lowest hitting index wins.
    always_comb begin
        w_sel_rgb = r_s1_rgb;
        for (int i = NRECT - 1; i >= 0; i--) begin
            if (r_s1_hit[i]) begin
                w_sel_rgb = r_s1_color[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_vcount <= 11'd0;
            r_out_vsync  <= 1'b0;
            r_out_vblnk  <= 1'b0;
            r_out_hcount <= 11'd0;
            r_out_hsync  <= 1'b0;
            r_out_hblnk  <= 1'b0;
            r_out_rgb    <= 12'd0;
        end else begin
            r_out_vcount <= r_s1_vcount;
            r_out_vsync  <= r_s1_vsync;
            r_out_vblnk  <= r_s1_vblnk;
            r_out_hcount <= r_s1_hcount;
            r_out_hsync  <= r_s1_hsync;
            r_out_hblnk  <= r_s1_hblnk;
            r_out_rgb    <= w_sel_rgb;
        end
    end

    assign vga_out.vcount = r_out_vcount;
    assign vga_out.vsync  = r_out_vsync;
    assign vga_out.vblnk  = r_out_vblnk;
    assign vga_out.hcount = r_out_hcount;
    assign vga_out.hsync  = r_out_hsync;
    assign vga_out.hblnk  = r_out_hblnk;
    assign vga_out.rgb    = r_out_rgb;

endmodule
`default_nettype wire
